ureg_shift: RTL
===============

# ureg_shift

Parametrised universal register for the FSM datapaths. It holds a WIDTH-bit value with hold, load, clear and single-step shift/rotate operations, and also runs a multi-cycle shift of a programmable number of positions under a start/busy/done handshake. It is the next generation of the single-bit enabled flip-flop: the same clock/reset/enable discipline, widened, with operating modes and a sequencer added.

## Interface
- WIDTH, 8: register width in bits (≥2)
- CNT_W, 4: width of shift-amount input and internal counter
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- en  input  1  global enable; 0 freezes q, state and counter
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_l  input  1  serial input into MSB on right shift
- sin_r  input  1  serial input into bit 0 on left shift
- start  input  1  request multi-cycle shift, sampled in IDLE
- amt  input  CNT_W  number of shift steps for a start
- q  output  WIDTH  register contents
- busy  output  1  high while state is RUN
- done  output  1  high for the single cycle in state DONE

## Operation
- Modes: 000 hold; 001 load d; 010 shl 1 (sin_r→bit0); 011 shr 1 (sin_l→MSB); 100 rol 1; 101 ror 1; 110 asr 1 (MSB replicated); 111 clear to 0.
- FSM states: IDLE, RUN, DONE. A counter cnt[CNT_W-1:0] and latched op op_r[2:0] are kept.
- IDLE, en=1, start=1, mode in 010..110: op_r←mode. If amt=0, go to DONE. Otherwise cnt←amt and go to RUN. q is unchanged on this edge.
- IDLE, en=1, any other case: the immediate mode is applied to q. start is ignored when mode is 000, 001 or 111.
- RUN, en=1: q←op_r step applied to q, cnt←cnt-1. If cnt=1, go to DONE. mode, d, start and amt are ignored. sin_l/sin_r are sampled at every RUN edge.
- DONE, en=1: go to IDLE. All inputs are ignored.
- en=0: nothing changes in any state. A DONE state persists, so done stays high.
- amt larger than WIDTH is legal and not clamped. Shifts fill completely with serial/sign bits; rotates wrap modulo WIDTH.
- Reset (rst=0, any time, including mid-RUN): q=0, state=IDLE, cnt=0, op_r=000, busy=0, done=0. Outputs change immediately, without a clock edge.

## Timing
- Immediate ops: the result appears on q after the capturing edge (1-cycle latency).
- Start accepted at edge k with amt=N>0: busy high after edge k through edge k+N. q takes its final value at edge k+N. done is high from edge k+N to edge k+N+1. A new start can be sampled at edge k+N+2.
- Start with amt=0 at edge k: done is high from edge k to edge k+1. busy never rises.
- Each cycle with en=0 during RUN or DONE extends these timings by one cycle.
- busy and done decode the state register only and are never both high.
- Reset release: the first active edge is the first one with rst=1.

## Configuration
- UREG_PARITY_EN defined: adds output port par (1 bit) = XOR of all q bits, combinational from q. Reset value is 0.
- UREG_PARITY_EN undefined: the par port and its logic do not exist. All other behaviour is identical.

## Test plan
- Reset: apply rst=0 mid-RUN (q=0x5A, cnt=2) → q=0x00, busy=0, done=0 immediately. After release, mode=000 holds 0x00.
- Immediate: load 0xA5, then ror → q=0xD2. Then shl with sin_r=1 → 0xA5. Then clear → 0x00.
- Multi-cycle: q=0x90, start, mode=110, amt=3 → busy for 3 cycles, q=0xF2, done high exactly 1 cycle. Inputs changed during RUN have no effect.
- Zero amount: q=0x3C, start, mode=100, amt=0 → done high the next cycle, busy stays 0, q=0x3C.
- Enable stall: start shr, amt=4 on q=0x80 with sin_l=0, en=0 for 2 cycles mid-RUN → cnt and q frozen. Final q=0x08. done is delayed by exactly 2 cycles.
- Over-width: q=0x00, start shl, amt=10, sin_r=1 → q=0xFF after 10 steps. With UREG_PARITY_EN, par=0.

Source files
------------

// File: rtl/ureg_shift.sv
// WIDTH-bit universal register: hold/load/clear/shift/rotate plus a multi-cycle shift sequencer.
// Optional parity output par_o is present when UREG_PARITY_EN is defined.
module ureg_shift #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] amt_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
`ifdef UREG_PARITY_EN
  ,
  output logic             par_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             is_shift_op;

  // One step of any shift/rotate op; non-shift codes pass the value through.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] op, input logic [WIDTH-1:0] v,
                                            input logic sl, input logic sr);
    logic [WIDTH-1:0] r;
    case (op)
      3'b010:  r = {v[WIDTH-2:0], sr};
      3'b011:  r = {sl, v[WIDTH-1:1]};
      3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b101:  r = {v[0], v[WIDTH-1:1]};
      3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign is_shift_op = (mode_i >= 3'b010) && (mode_i <= 3'b110);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    if (en_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i && is_shift_op) begin
            op_d = mode_i;
            if (amt_i == '0) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = amt_i;
              state_d = S_RUN;
            end
          end else begin
            case (mode_i)
              3'b000:  q_d = q_q;
              3'b001:  q_d = d_i;
              3'b111:  q_d = '0;
              default: q_d = step(mode_i, q_q, sin_l_i, sin_r_i);
            endcase
          end
        end
        S_RUN: begin
          q_d   = step(op_q, q_q, sin_l_i, sin_r_i);
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
    end
  end

  assign q_o     = q_q;
  assign busy_o  = (state_q == S_RUN);
  assign done_o  = (state_q == S_DONE);
  assign state_o = state_q;

`ifdef UREG_PARITY_EN
  assign par_o = ^q_q;
`endif

endmodule
